// File: rtl/pe_pkg.sv
// Shared definitions for the FP32 dot-product PE and its feeder.
package pe_pkg;
  localparam int FP32_W   = 32;
  localparam int PE_LANES = 5;
  localparam int PE_LAT   = 4;

  typedef enum logic [1:0] {IDLE, PH0, PH1} feed_state_t;
  typedef logic [FP32_W-1:0] fp32_t;

  function automatic logic fp32_sign(input fp32_t f);
    return f[31];
  endfunction

  function automatic logic [7:0] fp32_exp(input fp32_t f);
    return f[30:23];
  endfunction

  function automatic logic [22:0] fp32_man(input fp32_t f);
    return f[22:0];
  endfunction
endpackage

// File: rtl/pe_result_fifo.sv
// Show-ahead synchronous FIFO for PE results; push and pop may coincide even when full.
module pe_result_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/pe_fp32_feeder.sv
// Two-phase issue sequencer for pe_fp32 with a latency-matched tag pipe and
// credit-gated result FIFO, so the non-stallable PE never overruns it.
module pe_fp32_feeder import pe_pkg::*; #(
  parameter int LANES      = pe_pkg::PE_LANES,
  parameter int FIFO_DEPTH = 4,
  parameter int PE_LAT     = pe_pkg::PE_LAT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [LANES-1:0][FP32_W-1:0]  s_a,
  input  logic [LANES-1:0][FP32_W-1:0]  s_b,
  output logic [LANES-1:0][FP32_W-1:0]  pe_a,
  output logic [LANES-1:0][FP32_W-1:0]  pe_b,
  output logic                          pe_clk_cntr,
  input  logic [FP32_W-1:0]             pe_out,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [FP32_W-1:0]             m_data
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  feed_state_t   state, state_n;
  logic [CW-1:0] credits, credits_n;
  logic [CW-1:0] fifo_count;
  logic [PE_LAT:1] vld_pipe;
  logic          accept, pop, push, fifo_empty, fifo_full;

  assign accept  = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  assign push    = vld_pipe[PE_LAT];
  assign m_valid = !fifo_empty;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = PH0;
      PH0:     state_n = PH1;
      PH1:     state_n = accept ? PH0 : IDLE;
      default: state_n = IDLE;
    endcase
    credits_n = credits;
    if (accept && !pop)      credits_n = credits - 1'b1;
    else if (pop && !accept) credits_n = credits + 1'b1;
  end

  // s_ready and pe_* are registered from next-state values so they track state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      credits     <= CW'(FIFO_DEPTH);
      s_ready     <= 1'b0;
      pe_a        <= '0;
      pe_b        <= '0;
      pe_clk_cntr <= 1'b0;
      vld_pipe    <= '0;
    end else begin
      state       <= state_n;
      credits     <= credits_n;
      s_ready     <= (state_n == IDLE || state_n == PH1) && (credits_n != '0);
      pe_clk_cntr <= (state_n == PH1);
      if (accept) begin
        pe_a <= s_a;
        pe_b <= s_b;
      end else if (state_n == IDLE) begin
        pe_a <= '0;
        pe_b <= '0;
      end
      vld_pipe <= {vld_pipe[PE_LAT-1:1], state == PH1};
    end
  end

  pe_result_fifo #(.W(FP32_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (pe_out),
    .pop       (pop),
    .pop_data  (m_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
  a_credit_sum:  assert property (@(posedge clk) disable iff (rst)
                                  (credits + fifo_count) <= CW'(FIFO_DEPTH));
endmodule

// File: tb/tb_pe_fp32_feeder.sv
// Feeder + behavioural two-phase PE + real-valued dot-product scoreboard.
module tb_pe_fp32_feeder;
  localparam int LANES = 5;
  localparam int VW    = 32 * LANES;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, pe_clk_cntr, m_valid, m_ready;
  logic [VW-1:0] s_a, s_b, pe_a, pe_b;
  logic [31:0]   pe_out, m_data;
  int            checks = 0, errors = 0;

  always #5 clk = ~clk;

  pe_fp32_feeder #(.LANES(LANES), .FIFO_DEPTH(4), .PE_LAT(4)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .pe_a(pe_a), .pe_b(pe_b), .pe_clk_cntr(pe_clk_cntr), .pe_out(pe_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  function automatic real f2d(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = 11'(f[30:23]) + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] d2f(input real r);
    logic [63:0] b;
    logic [30:0] v;
    int          e;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    v = {e[7:0], b[51:29]} + 31'(b[28]);
    return {b[63], v};
  endfunction

  function automatic real dot_rng(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                  input int lo, input int hi);
    real s = 0.0;
    for (int i = lo; i <= hi; i++) s += f2d(a[32*i +: 32]) * f2d(b[32*i +: 32]);
    return s;
  endfunction

  function automatic bit ulp_ok(input logic [31:0] a, input logic [31:0] e);
    if (a === e) return 1'b1;
    if (a[31] !== e[31]) return 1'b0;
    return (a[30:0] - e[30:0] == 31'd1) || (e[30:0] - a[30:0] == 31'd1);
  endfunction

  function automatic logic [VW-1:0] pk(input logic [31:0] l0, input logic [31:0] l1,
                                       input logic [31:0] l2, input logic [31:0] l3,
                                       input logic [31:0] l4);
    return {l4, l3, l2, l1, l0};
  endfunction

  // PE model: low lanes summed in the clk_cntr=0 cycle, high lanes added in the
  // clk_cntr=1 cycle; result held on pe_out 4 cycles after that cycle. No reset.
  real         pe_lo = 0.0;
  logic [31:0] pe_s0 = '0, pe_s1 = '0, pe_s2 = '0;
  initial pe_out = '0;
  always @(posedge clk) begin
    if (!pe_clk_cntr) pe_lo <= dot_rng(pe_a, pe_b, 0, 2);
    else              pe_s0 <= d2f(pe_lo + dot_rng(pe_a, pe_b, 3, 4));
    pe_s1  <= pe_s0;
    pe_s2  <= pe_s1;
    pe_out <= pe_s2;
  end

  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected: got %h, required no result", m_data);
        end else begin
          sb_exp = exp_q.pop_front();
          if (!ulp_ok(m_data, sb_exp)) begin
            errors++;
            $display("FAIL result_data: got %h, required %h", m_data, sb_exp);
          end
        end
      end
      if (s_valid && s_ready) exp_q.push_back(d2f(dot_rng(s_a, s_b, 0, LANES-1)));
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, act, exp);
    end
  endtask

  task automatic rand_pair();
    for (int i = 0; i < LANES; i++) begin
      s_a[32*i +: 32] = d2f(real'($urandom_range(0, 14)) - 7.0);
      s_b[32*i +: 32] = d2f(real'($urandom_range(0, 14)) - 7.0);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Hold current s_valid/m_ready for ncyc cycles, fresh random pair after each accept.
  task automatic hold(input int ncyc, output int nacc);
    bit took;
    nacc = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      took = s_valid && s_ready;
      if (took) nacc++;
      step();
      if (took) rand_pair();
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    m_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin step(); n++; end
    chk("drain_left", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic [31:0]   exp;
  } vec_t;

  task automatic run_vec(input vec_t v, input string n);
    int lat = 0;
    s_valid = 1'b1; s_a = v.a; s_b = v.b; m_ready = 1'b1;
    @(negedge clk);
    while (!s_ready && lat < 20) begin step(); @(negedge clk); lat++; end
    chk({n, "_accept"}, s_ready, 1'b1);
    step();
    s_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!m_valid && lat < 30) begin step(); @(negedge clk); lat++; end
    chk({n, "_latency"}, lat, 7);
    chk({n, "_data"}, m_data, v.exp);
    step();
  endtask

  vec_t tbl[6];
  vec_t zv;

  initial begin
    int acc, first, cyc, n1, n2;
    bit took, saw;
    tbl[0] = '{pk(32'h3F800000, 32'h3F800000, 0, 0, 0), pk(32'h40000000, 32'h3F800000, 0, 0, 0), 32'h40400000};
    tbl[1] = '{{5{32'h3F800000}}, {5{32'h3F800000}}, 32'h40A00000};
    tbl[2] = '{pk(0, 0, 0, 0, 32'h40000000), pk(0, 0, 0, 0, 32'hC0400000), 32'hC0C00000};
    tbl[3] = '{'0, '0, 32'h00000000};
    tbl[4] = '{pk(0, 0, 32'h3F000000, 0, 0), pk(0, 0, 32'h3F000000, 0, 0), 32'h3E800000};
    tbl[5] = '{pk(32'h3F800000, 0, 0, 32'h40800000, 0), pk(32'hBF800000, 0, 0, 32'h3FC00000, 0), 32'h40A00000};

    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_a = '0; s_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {s_ready, |pe_a, |pe_b, pe_clk_cntr, m_valid}, 5'b0);
    step(); rst = 1'b0;
    step();

    // Directed vectors, one pair at a time
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Idle: PE inputs parked at zero, ready to accept
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_pe", {|pe_a, |pe_b, pe_clk_cntr}, 3'b0);
      chk("idle_ready", s_ready, 1'b1);
      step();
    end

    // Back-to-back stream of 8 pairs
    m_ready = 1'b1; rand_pair(); s_valid = 1'b1;
    acc = 0; first = -1; cyc = 0;
    while (acc < 8 && cyc < 100) begin
      @(negedge clk);
      if (first >= 0) begin
        chk("stream_ready", s_ready, ((cyc - first) % 2 == 0));
        chk("stream_cntr", pe_clk_cntr, ((cyc - first) % 2 == 0));
      end
      took = s_ready;
      if (took) begin acc++; if (first < 0) first = cyc; end
      step(); cyc++;
      if (took) rand_pair();
    end
    s_valid = 1'b0;
    chk("stream_accepts", acc, 8);
    wait_drain();

    // Back-pressure: credits cap accepts at FIFO depth
    m_ready = 1'b0; s_valid = 1'b1; rand_pair();
    hold(30, n1);
    chk("fill_accepts", n1, 4);
    @(negedge clk);
    chk("fill_ready", s_ready, 1'b0);
    chk("fill_valid", m_valid, 1'b1);
    step();
    m_ready = 1'b1;
    hold(1, n1);
    m_ready = 1'b0;
    hold(20, n2);
    chk("one_pop_one_accept", n1 + n2, 1);
    @(negedge clk);
    chk("refull_valid", m_valid, 1'b1);
    step();

    // From a full FIFO: pop and accept coincide in a PH1 cycle
    m_ready = 1'b1; saw = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      took = s_valid && s_ready;
      if (took && m_valid && pe_clk_cntr) saw = 1'b1;
      step();
      if (took) rand_pair();
    end
    chk("ph1_accept_pop", saw, 1'b1);
    s_valid = 1'b0;
    wait_drain();

    // Credits fully restored: exactly 4 accepts again
    m_ready = 1'b0; s_valid = 1'b1; rand_pair();
    hold(30, n1);
    chk("refill_accepts", n1, 4);
    s_valid = 1'b0;
    wait_drain();

    // Reset with two ops in flight
    s_valid = 1'b1; rand_pair(); n1 = 0; cyc = 0;
    while (n1 < 2 && cyc < 20) begin hold(1, n2); n1 += n2; cyc++; end
    chk("pre_rst_accepts", n1, 2);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {s_ready, |pe_a, |pe_b, pe_clk_cntr, m_valid}, 5'b0);
    step(); rst = 1'b0;
    n1 = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (m_valid) n1++;
      step();
    end
    chk("dropped_results", n1, 0);
    zv = tbl[3];
    run_vec(zv, "post_rst_zero");
    chk("final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end
endmodule
